csr_access_unit: RTL and testbench

- Initiator side of the CSR file port: the only block that drives csr_file's write enable, address and write data, and consumes its read data and mtvec/mepc taps.
- Executes decoded Zicsr instructions (CSRRW/S/C and immediate forms) as a read-modify-write and returns the old CSR value.
- Sequences machine-mode trap entry (writes mepc, then mcause, then redirects to mtvec) and mret (redirects to mepc).
- Sits between the controller/decoder and csr_file.

---
 rtl/csr_access_unit_pkg.sv | 33 +++
 rtl/csr_access_unit_alu.sv | 37 +++
 rtl/csr_access_unit.sv | 142 ++++++++++++++
 tb/tb_csr_access_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_access_unit_pkg.sv
// Shared definitions for the CSR access unit: CSR addresses, Zicsr funct3
// encodings and FSM states.
package csr_access_unit_pkg;

  typedef enum logic [11:0] {
    CSR_MTVEC  = 12'h305,
    CSR_MEPC   = 12'h341,
    CSR_MCAUSE = 12'h342
  } csr_addr_e;

  typedef enum logic [2:0] {
    F3_CSRRW  = 3'b001,
    F3_CSRRS  = 3'b010,
    F3_CSRRC  = 3'b011,
    F3_CSRRWI = 3'b101,
    F3_CSRRSI = 3'b110,
    F3_CSRRCI = 3'b111
  } funct3_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_TRAP_EPC,
    S_TRAP_CAUSE,
    S_REDIRECT
  } state_e;

  // Immediate forms take their operand from the zero-extended rs1 field.
  function automatic logic is_imm_form(input logic [2:0] funct3);
    return funct3[2];
  endfunction

endpackage

// File: rtl/csr_access_unit_alu.sv
// Zicsr read-modify-write datapath: computes the new CSR value, whether the
// access writes at all, and whether funct3 is a legal CSR encoding.
module csr_access_unit_alu
  import csr_access_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] operand,
  input  logic            src_zero,
  output logic [XLEN-1:0] new_val,
  output logic            we,
  output logic            illegal
);

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    new_val = operand;
    we      = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_CSRRW, F3_CSRRWI: we = 1'b1;
      F3_CSRRS, F3_CSRRSI: begin
        new_val = old_val | operand;
        we      = !src_zero;
      end
      F3_CSRRC, F3_CSRRCI: begin
        new_val = old_val & ~operand;
        we      = !src_zero;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/csr_access_unit.sv
// CSR file initiator: Zicsr read-modify-write, trap entry and mret redirect.
// Define CSR_RO_CHECK_EN to reject writes to the read-only CSR space.
module csr_access_unit
  import csr_access_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_rs1_data,
  input  logic [4:0]        req_src_idx,
  input  logic              trap_valid,
  input  logic [XLEN-1:0]   trap_pc,
  input  logic [XLEN-1:0]   trap_cause,
  input  logic              mret_valid,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_data,
  output logic              resp_illegal,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              csr_we,
  output logic [ADDR_W-1:0] csr_addr,
  output logic [XLEN-1:0]   csr_wdata,
  input  logic [XLEN-1:0]   csr_rdata,
  input  logic [XLEN-1:0]   csr_mtvec,
  input  logic [XLEN-1:0]   csr_mepc
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  state_e            state_q, state_d;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   opnd_q;
  logic [XLEN-1:0]   cause_q;
  logic              src_zero_q;

  logic              take_trap, take_mret, take_req;
  logic [XLEN-1:0]   alu_new;
  logic              alu_we, alu_illegal;
  logic              ro_viol, exec_illegal, we_raw;

  assign req_ready = (state_q == S_IDLE) && !trap_valid && !mret_valid;
  assign take_trap = (state_q == S_IDLE) && trap_valid;
  assign take_mret = (state_q == S_IDLE) && !trap_valid && mret_valid;
  assign take_req  = req_ready && req_valid;

  csr_access_unit_alu #(.XLEN(XLEN)) u_alu (
    .funct3   (f3_q),
    .old_val  (csr_rdata),
    .operand  (opnd_q),
    .src_zero (src_zero_q),
    .new_val  (alu_new),
    .we       (alu_we),
    .illegal  (alu_illegal)
  );

`ifdef CSR_RO_CHECK_EN
  assign ro_viol = alu_we && (addr_q[ADDR_W-1 -: 2] == 2'b11);
`else
  assign ro_viol = 1'b0;
`endif
  assign exec_illegal = alu_illegal || ro_viol;

  // NOTE: operand/address holding registers carry no reset; they are always
  // loaded on acceptance before any state reads them.
  always_ff @(posedge clk) begin
    if (take_trap) begin
      opnd_q  <= trap_pc;
      cause_q <= trap_cause;
    end else if (take_req) begin
      f3_q       <= req_funct3;
      addr_q     <= req_addr;
      opnd_q     <= is_imm_form(req_funct3) ? XLEN'(req_src_idx) : req_rs1_data;
      src_zero_q <= (req_src_idx == 5'd0);
    end
  end

  always_comb begin
    state_d   = state_q;
    we_raw    = 1'b0;
    csr_addr  = '0;
    csr_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if (take_trap)      state_d = S_TRAP_EPC;
        else if (take_mret) state_d = S_REDIRECT;
        else if (take_req)  state_d = S_EXEC;
      end
      S_EXEC: begin
        csr_addr  = addr_q;
        csr_wdata = alu_new;
        we_raw    = alu_we && !ro_viol;
        state_d   = S_IDLE;
      end
      S_TRAP_EPC: begin
        csr_addr  = ADDR_W'(CSR_MEPC);
        csr_wdata = opnd_q & ALIGN_MASK;
        we_raw    = 1'b1;
        state_d   = S_TRAP_CAUSE;
      end
      S_TRAP_CAUSE: begin
        csr_addr  = ADDR_W'(CSR_MCAUSE);
        csr_wdata = cause_q;
        we_raw    = 1'b1;
        state_d   = S_REDIRECT;
      end
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // A reset landing mid-sequence must not let the pending write through.
  assign csr_we = we_raw && !rst;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      resp_valid     <= 1'b0;
      resp_data      <= '0;
      resp_illegal   <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state_q        <= state_d;
      resp_valid     <= (state_q == S_EXEC);
      resp_illegal   <= (state_q == S_EXEC) && exec_illegal;
      redirect_valid <= (state_d == S_REDIRECT);
      if (state_q == S_EXEC) resp_data <= exec_illegal ? '0 : csr_rdata;
      if (take_mret) redirect_pc <= csr_mepc;
      else if (state_q == S_TRAP_CAUSE) redirect_pc <= csr_mtvec & ALIGN_MASK;
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit: vector table, hand-written trap,
// mret and reset-abort sequences, then random CSR ops against a model.
module tb_csr_access_unit;

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [31:0] rs1;
    logic [4:0]  src;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_resp;
    logic        exp_ill;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [31:0] req_rs1_data;
  logic [4:0]  req_src_idx;
  logic        trap_valid;
  logic [31:0] trap_pc, trap_cause;
  logic        mret_valid;
  logic        resp_valid, resp_illegal;
  logic [31:0] resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata, csr_mtvec, csr_mepc;

  int n_err = 0;
  int n_chk = 0;

  // Behavioural CSR file answering the DUT, and the bench's own expectation.
  logic [31:0] csr_mem [4096] = '{default: '0};
  logic [31:0] ref_mem [4096];

  always #5 clk = ~clk;

  always @(posedge clk) if (csr_we) csr_mem[csr_addr] <= csr_wdata;
  assign csr_rdata = csr_mem[csr_addr];
  assign csr_mtvec = csr_mem[12'h305];
  assign csr_mepc  = csr_mem[12'h341];

  csr_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_rs1_data(req_rs1_data), .req_src_idx(req_src_idx),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .mret_valid(mret_valid),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_illegal(resp_illegal),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] f3, input logic [11:0] addr,
                              input logic [31:0] rs1, input logic [4:0] src,
                              input logic we, input logic [31:0] wdata,
                              input logic [31:0] resp, input logic ill);
    vec_t v;
    v.f3 = f3; v.addr = addr; v.rs1 = rs1; v.src = src;
    v.exp_we = we; v.exp_wdata = wdata; v.exp_resp = resp; v.exp_ill = ill;
    return v;
  endfunction

  // Reference: Zicsr semantics straight from the instruction definitions.
  function automatic vec_t model_op(input logic [2:0] f3, input logic [11:0] addr,
                                    input logic [31:0] rs1, input logic [4:0] src);
    logic [31:0] old_v, opnd;
    vec_t v;
    old_v = ref_mem[addr];
    opnd  = f3[2] ? {27'd0, src} : rs1;
    v = mk(f3, addr, rs1, src, 1'b0, 32'd0, old_v, 1'b0);
    if (f3 == 3'd0 || f3 == 3'd4) begin
      v.exp_ill  = 1'b1;
      v.exp_resp = 32'd0;
    end else begin
      case (f3[1:0])
        2'd1:    v.exp_wdata = opnd;
        2'd2:    v.exp_wdata = old_v | opnd;
        default: v.exp_wdata = old_v & ~opnd;
      endcase
      v.exp_we = (f3[1:0] == 2'd1) || (src != 5'd0);
`ifdef CSR_RO_CHECK_EN
      if (v.exp_we && addr[11:10] == 2'b11) begin
        v.exp_we   = 1'b0;
        v.exp_ill  = 1'b1;
        v.exp_resp = 32'd0;
      end
`endif
    end
    return v;
  endfunction

  // Starts and ends just after a falling edge.
  task automatic run_op(input vec_t v);
    req_valid = 1'b1; req_funct3 = v.f3; req_addr = v.addr;
    req_rs1_data = v.rs1; req_src_idx = v.src;
    #1;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("exec_we", 32'(csr_we), 32'(v.exp_we));
    check("exec_addr", 32'(csr_addr), 32'(v.addr));
    if (v.exp_we) check("exec_wdata", csr_wdata, v.exp_wdata);
    check("resp_not_early", 32'(resp_valid), 32'd0);
    @(negedge clk);
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_data", resp_data, v.exp_resp);
    check("resp_illegal", 32'(resp_illegal), 32'(v.exp_ill));
    check("req_ready_resp", 32'(req_ready), 32'd1);
    if (v.exp_we) ref_mem[v.addr] = v.exp_wdata;
    @(negedge clk);
    check("resp_pulse_end", 32'(resp_valid), 32'd0);
  endtask

  vec_t tbl [14];
  logic [11:0] rnd_addrs [4] = '{12'h340, 12'h341, 12'h300, 12'hC01};

  initial begin
    foreach (ref_mem[i]) ref_mem[i] = 32'd0;
    tbl[0]  = mk(3'b001, 12'h340, 32'hDEADBEEF, 5'd1, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0);
    tbl[1]  = mk(3'b001, 12'h340, 32'h000000F0, 5'd2, 1'b1, 32'h000000F0, 32'hDEADBEEF, 1'b0);
    tbl[2]  = mk(3'b010, 12'h340, 32'h0000000F, 5'd3, 1'b1, 32'h000000FF, 32'hF0, 1'b0);
    tbl[3]  = mk(3'b011, 12'h340, 32'h0000000F, 5'd3, 1'b1, 32'h000000F0, 32'hFF, 1'b0);
    tbl[4]  = mk(3'b110, 12'h340, 32'hFFFFFFFF, 5'd0, 1'b0, 32'h0, 32'hF0, 1'b0);
    tbl[5]  = mk(3'b010, 12'h340, 32'h0000FFFF, 5'd0, 1'b0, 32'h0, 32'hF0, 1'b0);
    tbl[6]  = mk(3'b100, 12'h340, 32'h12345678, 5'd9, 1'b0, 32'h0, 32'h0, 1'b1);
    tbl[7]  = mk(3'b000, 12'h340, 32'h12345678, 5'd9, 1'b0, 32'h0, 32'h0, 1'b1);
    tbl[8]  = mk(3'b101, 12'h341, 32'hFFFFFFFF, 5'h1F, 1'b1, 32'h1F, 32'h0, 1'b0);
    tbl[9]  = mk(3'b111, 12'h341, 32'h0, 5'h03, 1'b1, 32'h1C, 32'h1F, 1'b0);
    tbl[10] = mk(3'b110, 12'h341, 32'h0, 5'h01, 1'b1, 32'h1D, 32'h1C, 1'b0);
    tbl[11] = mk(3'b001, 12'h305, 32'h00000103, 5'd4, 1'b1, 32'h103, 32'h0, 1'b0);
`ifdef CSR_RO_CHECK_EN
    tbl[12] = mk(3'b001, 12'hC00, 32'h5, 5'd3, 1'b0, 32'h0, 32'h0, 1'b1);
    tbl[13] = mk(3'b010, 12'hC00, 32'h77, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);
`else
    tbl[12] = mk(3'b001, 12'hC00, 32'h5, 5'd3, 1'b1, 32'h5, 32'h0, 1'b0);
    tbl[13] = mk(3'b010, 12'hC00, 32'h77, 5'd0, 1'b0, 32'h0, 32'h5, 1'b0);
`endif

    rst = 1'b1; req_valid = 1'b0; trap_valid = 1'b0; mret_valid = 1'b0;
    req_funct3 = 3'd0; req_addr = 12'd0; req_rs1_data = 32'd0; req_src_idx = 5'd0;
    trap_pc = 32'd0; trap_cause = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_illegal", 32'(resp_illegal), 32'd0);
    check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_csr_we", 32'(csr_we), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    foreach (tbl[i]) run_op(tbl[i]);

    // Trap with a competing request: trap wins, request is not taken.
    trap_valid = 1'b1; trap_pc = 32'h200; trap_cause = 32'h2;
    req_valid = 1'b1; req_funct3 = 3'b001; req_addr = 12'h340; req_rs1_data = 32'h55;
    #1;
    check("trap_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    trap_valid = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("epc_we", 32'(csr_we), 32'd1);
    check("epc_addr", 32'(csr_addr), 32'h341);
    check("epc_wdata", csr_wdata, 32'h200);
    @(negedge clk);
    check("cause_we", 32'(csr_we), 32'd1);
    check("cause_addr", 32'(csr_addr), 32'h342);
    check("cause_wdata", csr_wdata, 32'h2);
    check("trap_no_resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    check("trap_redirect_valid", 32'(redirect_valid), 32'd1);
    check("trap_redirect_pc", redirect_pc, 32'h100);
    check("redirect_no_we", 32'(csr_we), 32'd0);
    @(negedge clk);
    check("trap_redirect_end", 32'(redirect_valid), 32'd0);
    check("trap_ready_again", 32'(req_ready), 32'd1);
    ref_mem[12'h341] = 32'h200;
    ref_mem[12'h342] = 32'h2;

    // mret returns to the saved mepc on the next cycle.
    mret_valid = 1'b1; req_valid = 1'b1;
    #1;
    check("mret_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    mret_valid = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("mret_redirect_valid", 32'(redirect_valid), 32'd1);
    check("mret_redirect_pc", redirect_pc, 32'h200);
    check("mret_no_we", 32'(csr_we), 32'd0);
    @(negedge clk);
    check("mret_redirect_end", 32'(redirect_valid), 32'd0);

    // Trap beats a simultaneous mret; reset in TRAP_CAUSE aborts the entry.
    trap_valid = 1'b1; mret_valid = 1'b1; trap_pc = 32'h20E; trap_cause = 32'h7;
    @(posedge clk); #1;
    trap_valid = 1'b0; mret_valid = 1'b0;
    @(negedge clk);
    check("epc2_we", 32'(csr_we), 32'd1);
    check("epc2_wdata_aligned", csr_wdata, 32'h20C);
    check("epc2_no_mret", 32'(redirect_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_we_low", 32'(csr_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(req_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      check("abort_no_redirect", 32'(redirect_valid), 32'd0);
      check("abort_no_resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
    end
    check("abort_mcause_kept", csr_mem[12'h342], 32'h2);
    ref_mem[12'h341] = 32'h20C;

    for (int k = 0; k < 40; k++) begin
      logic [2:0]  f3;
      logic [11:0] a;
      logic [4:0]  s;
      f3 = 3'($urandom_range(0, 7));
      a  = rnd_addrs[$urandom_range(0, 3)];
      s  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      run_op(model_op(f3, a, $urandom, s));
    end
    foreach (rnd_addrs[i]) check("final_csr_state", csr_mem[rnd_addrs[i]], ref_mem[rnd_addrs[i]]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
